// File: rtl/control_multiciclo_pkg.sv
// rtl/control_multiciclo_pkg.sv - shared opcodes, ALU control codes, mux codes and state encoding
package control_multiciclo_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_SLTI = 6'b001010;

    localparam logic [2:0] UC_FUNCT = 3'b000;
    localparam logic [2:0] UC_ADD   = 3'b010;
    localparam logic [2:0] UC_OR    = 3'b001;
    localparam logic [2:0] UC_AND   = 3'b011;
    localparam logic [2:0] UC_SLT   = 3'b111;
    localparam logic [2:0] UC_SUB   = 3'b110;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_EXEC_R    = 4'd3,
        S_R_WB      = 4'd4,
        S_EXEC_I    = 4'd5,
        S_I_WB      = 4'd6,
        S_MEM_ADDR  = 4'd7,
        S_MEM_READ  = 4'd8,
        S_MEM_WB    = 4'd9,
        S_MEM_WRITE = 4'd10,
        S_BRANCH    = 4'd11,
        S_JUMP      = 4'd12
    } state_e;

endpackage

// File: rtl/control_multiciclo_alu_op_decode.sv
// rtl/control_multiciclo_alu_op_decode.sv - opcode to I-type ALU operation decoder
module alu_op_decode
    import control_multiciclo_pkg::*;
(
    input  logic [5:0] opcode,
    output logic [2:0] aluOp,
    output logic       isIType
);

    always_comb begin
        aluOp   = UC_ADD;
        isIType = 1'b1;
        case (opcode)
            OP_ADDI: aluOp = UC_ADD;
            OP_ORI:  aluOp = UC_OR;
            OP_ANDI: aluOp = UC_AND;
            OP_SLTI: aluOp = UC_SLT;
            default: isIType = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_multiciclo.sv
// rtl/control_multiciclo.sv - multi-cycle MIPS main control FSM
module control_multiciclo
    import control_multiciclo_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [5:0]             opcode,
    input  logic                   memReady,
    output logic                   pcWrite,
    output logic                   pcWriteCond,
    output logic                   iorD,
    output logic                   memRead,
    output logic                   memWrite,
    output logic                   irWrite,
    output logic                   memToReg,
    output logic                   regDst,
    output logic                   regWrite,
    output logic                   aluSrcA,
    output logic [1:0]             aluSrcB,
    output logic [1:0]             pcSource,
    output logic [2:0]             unitControl,
    output logic                   illegalOp,
    output logic [COUNT_WIDTH-1:0] instrCount
);

    state_e                 state_q, state_d;
    logic [2:0]             aluop_q, aluop_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [2:0]             dec_aluop;
    logic                   dec_itype;
    logic                   retire;

    alu_op_decode u_alu_op_decode (
        .opcode  (opcode),
        .aluOp   (dec_aluop),
        .isIType (dec_itype)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            aluop_q <= UC_FUNCT;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            aluop_q <= aluop_d;
            count_q <= count_d;
        end
    end

    // Only completed instructions count; an illegal opcode returns to FETCH from DECODE and is skipped.
    assign retire = (state_d == S_FETCH) &&
                    (state_q inside {S_R_WB, S_I_WB, S_MEM_WB, S_MEM_WRITE, S_BRANCH, S_JUMP});
    assign count_d = retire ? count_q + COUNT_WIDTH'(1) : count_q;
    assign aluop_d = (state_q == S_DECODE) ? dec_aluop : aluop_q;
    assign instrCount = count_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      state_d = S_FETCH;
            S_FETCH:     if (memReady) state_d = S_DECODE;
            S_DECODE: begin
                if (opcode == OP_R)                         state_d = S_EXEC_R;
                else if (opcode == OP_LW || opcode == OP_SW) state_d = S_MEM_ADDR;
                else if (opcode == OP_BEQ)                  state_d = S_BRANCH;
                else if (opcode == OP_J)                    state_d = S_JUMP;
                else if (dec_itype)                         state_d = S_EXEC_I;
                else                                        state_d = S_FETCH;
            end
            S_EXEC_R:    state_d = S_R_WB;
            S_R_WB:      state_d = S_FETCH;
            S_EXEC_I:    state_d = S_I_WB;
            S_I_WB:      state_d = S_FETCH;
            S_MEM_ADDR:  state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  if (memReady) state_d = S_MEM_WB;
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: if (memReady) state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        iorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        irWrite     = 1'b0;
        memToReg    = 1'b0;
        regDst      = 1'b0;
        regWrite    = 1'b0;
        aluSrcA     = 1'b0;
        aluSrcB     = SRCB_REGB;
        pcSource    = PCSRC_ALU;
        unitControl = UC_FUNCT;
        illegalOp   = 1'b0;
        case (state_q)
            S_FETCH: begin
                // IR and PC load in the same cycle the memory returns the word
                memRead     = 1'b1;
                aluSrcB     = SRCB_FOUR;
                unitControl = UC_ADD;
                irWrite     = memReady;
                pcWrite     = memReady;
            end
            S_DECODE: begin
                aluSrcB     = SRCB_IMM_SH2;
                unitControl = UC_ADD;
                illegalOp   = (state_d == S_FETCH);
            end
            S_EXEC_R: aluSrcA = 1'b1;
            S_R_WB: begin
                regDst   = 1'b1;
                regWrite = 1'b1;
            end
            S_EXEC_I: begin
                aluSrcA     = 1'b1;
                aluSrcB     = SRCB_IMM;
                unitControl = aluop_q;
            end
            S_I_WB: begin
                regWrite    = 1'b1;
                unitControl = aluop_q;
            end
            S_MEM_ADDR: begin
                aluSrcA     = 1'b1;
                aluSrcB     = SRCB_IMM;
                unitControl = UC_ADD;
            end
            S_MEM_READ: begin
                memRead = 1'b1;
                iorD    = 1'b1;
            end
            S_MEM_WB: begin
                memToReg = 1'b1;
                regWrite = 1'b1;
            end
            S_MEM_WRITE: begin
                memWrite = 1'b1;
                iorD     = 1'b1;
            end
            S_BRANCH: begin
                aluSrcA     = 1'b1;
                unitControl = UC_SUB;
                pcWriteCond = 1'b1;
                pcSource    = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                pcWrite  = 1'b1;
                pcSource = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/control_multiciclo.md
Name: control_multiciclo

Overview:
Multi-cycle MIPS main control unit. Moore-style FSM that sequences one instruction over 3-5 states plus memory wait cycles. Drives the datapath muxes and register/memory enables, and supplies the 3-bit unitControl code consumed by the ALU control decoder. Sits between the instruction register opcode field and the shared single-ALU datapath, and waits on a memory ready handshake.

Parameters:
COUNT_WIDTH, 32, width of retired-instruction counter instrCount

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
opcode  input  6  instr[31:26] from instruction register
memReady  input  1  memory completed the current read/write this cycle
pcWrite  output  1  unconditional PC load
pcWriteCond  output  1  PC load if ALU zero (branch)
iorD  output  1  memory address mux: 0=PC, 1=ALUOut
memRead  output  1  memory read request
memWrite  output  1  memory write request
irWrite  output  1  instruction register load
memToReg  output  1  write-back mux: 0=ALUOut, 1=MDR
regDst  output  1  dest mux: 0=rt, 1=rd
regWrite  output  1  register file write enable
aluSrcA  output  1  0=PC, 1=regA
aluSrcB  output  2  00=regB, 01=const 4, 10=signext imm, 11=signext imm<<2
pcSource  output  2  00=ALU result, 01=ALUOut, 10=jump target
unitControl  output  3  to ALU control: 000 R-type(funct), 010 add, 001 or, 011 and, 111 slt, 110 sub
illegalOp  output  1  one-cycle pulse on unsupported opcode
instrCount  output  COUNT_WIDTH  instructions retired since reset, wraps

Behaviour:
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000, andi 001100, ori 001101, slti 001010. Any other opcode is illegal.
- Reset: state=IDLE, instrCount=0, aluOpReg=000.
- Output defaults: every 1-bit output is 0, aluSrcB/pcSource=00, unitControl=000, in every state unless listed below.
- IDLE: all outputs at default. Next state is FETCH unconditionally.
- FETCH: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, unitControl=010.
  - If memReady: irWrite=1 and pcWrite=1 in that cycle only (Mealy on memReady), pcSource=00, next state DECODE.
  - Else stay in FETCH with irWrite and pcWrite at 0.
- DECODE: aluSrcA=0, aluSrcB=11, unitControl=010 (branch target into ALUOut). Latch aluOpReg from opcode (addi 010, ori 001, andi 011, slti 111).
  - Next state: R->EXEC_R; lw/sw->MEM_ADDR; beq->BRANCH; j->JUMP; I-ALU->EXEC_I.
  - Illegal: illegalOp=1 this cycle, next state FETCH, instrCount not incremented.
- EXEC_R: aluSrcA=1, aluSrcB=00, unitControl=000. Next state R_WB.
- R_WB: regDst=1, memToReg=0, regWrite=1, unitControl=000. Next state FETCH.
- EXEC_I: aluSrcA=1, aluSrcB=10, unitControl=aluOpReg. Next state I_WB.
- I_WB: regDst=0, memToReg=0, regWrite=1, unitControl=aluOpReg. Next state FETCH.
- MEM_ADDR: aluSrcA=1, aluSrcB=10, unitControl=010. Next state MEM_READ (lw) or MEM_WRITE (sw), using the opcode held in IR.
- MEM_READ: memRead=1, iorD=1. Hold until memReady, then MEM_WB.
- MEM_WB: regDst=0, memToReg=1, regWrite=1. Next state FETCH.
- MEM_WRITE: memWrite=1, iorD=1. Hold until memReady, then FETCH.
- BRANCH: aluSrcA=1, aluSrcB=00, unitControl=110, pcWriteCond=1, pcSource=01. Next state FETCH.
- JUMP: pcWrite=1, pcSource=10. Next state FETCH.
- instrCount increments by 1 on each transition into FETCH from R_WB, I_WB, MEM_WB, MEM_WRITE, BRANCH or JUMP. It wraps modulo 2^COUNT_WIDTH.
- Latencies excluding memory waits: R/I 4 cycles, lw 5, sw 4, beq 3, j 3.
- memReady is ignored in every state except FETCH, MEM_READ and MEM_WRITE.
- Reset has priority in any state, including mid-wait: the next cycle is IDLE with all outputs at default; in-flight writes are abandoned.
- Once asserted, memRead/memWrite stay high continuously until the cycle memReady is sampled high.

Decomposition:
- Shared package: opcode constants, unitControl codes (000/010/001/011/111/110), state encoding (4-bit, IDLE..JUMP), aluSrcB/pcSource mux codes.
- One sub-module: alu_op_decode, combinational opcode->{aluOp[2:0], isIType}, instanced for the DECODE latch.

Test Plan:
1. Reset mid-MEM_READ with memReady=0 -> next cycle all outputs 0, instrCount=0; FETCH one cycle later with memRead=1, aluSrcB=01.
2. add (opcode 000000), memReady=1 in FETCH -> 4 cycles FETCH/DECODE/EXEC_R/R_WB; EXEC_R unitControl=000; R_WB regDst=1, regWrite=1; instrCount 0->1.
3. lw with memReady delayed 3 cycles in MEM_READ -> memRead=1, iorD=1 held 4 cycles; MEM_WB memToReg=1, regWrite=1; total 8 cycles.
4. ori (001101) then slti (001010) -> EXEC_I unitControl=001 then 111; beq (000100) -> BRANCH unitControl=110, pcWriteCond=1, pcSource=01.
5. Illegal opcode 111111 -> illegalOp=1 for exactly one cycle in DECODE, return to FETCH, instrCount unchanged; j (000010) -> pcWrite=1, pcSource=10.
6. COUNT_WIDTH=4, 16 back-to-back j instructions -> instrCount wraps 15->0.
